// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared width, state type and arithmetic helpers for the LIF neuron datapath
package neuron_pkg;

  localparam int NEURON_W = 21;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAK,
    ST_GAIN,
    ST_UPDATE,
    ST_HOLD
  } state_e;

  // The downstream shift unit only implements this subset of amounts.
  function automatic bit shift_legal(input int s);
    return (s == 3) || (s == 4) || ((s >= 6) && (s <= 9));
  endfunction

  function automatic logic signed [NEURON_W-1:0] sat21(
    input logic signed [NEURON_W-1:0] a,
    input logic signed [NEURON_W-1:0] b,
    input logic                       sub
  );
    logic signed [NEURON_W:0] a_x;
    logic signed [NEURON_W:0] b_x;
    logic signed [NEURON_W:0] s;
    a_x = {a[NEURON_W-1], a};
    b_x = {b[NEURON_W-1], b};
    s   = sub ? (a_x - b_x) : (a_x + b_x);
    if (s[NEURON_W] != s[NEURON_W-1]) begin
      return s[NEURON_W] ? {1'b1, {(NEURON_W-1){1'b0}}} : {1'b0, {(NEURON_W-1){1'b1}}};
    end
    return s[NEURON_W-1:0];
  endfunction

endpackage

// File: rtl/lif_sat_addsub.sv
// rtl/lif_sat_addsub.sv - 21-bit signed add/subtract clamped to the representable range
module lif_sat_addsub
  import neuron_pkg::*;
(
  input  logic signed [NEURON_W-1:0] a,
  input  logic signed [NEURON_W-1:0] b,
  input  logic                       sub,
  output logic signed [NEURON_W-1:0] y
);

  always_comb begin
    y = sat21(a, b, sub);
  end

endmodule

// File: rtl/lif_neuron_integrator.sv
// rtl/lif_neuron_integrator.sv - leaky-integrate-and-fire update stage driving an external shift unit
// Optional saturating spike counter with clear: define LIF_SPIKE_COUNT_EN.
module lif_neuron_integrator
  import neuron_pkg::*;
#(
  parameter int LEAK_SHIFT    = 4,
  parameter int GAIN_SHIFT    = 3,
  parameter int V_TH          = 1000,
  parameter int V_RESET       = 0,
  parameter int REFRAC_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [NEURON_W-1:0] i_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [NEURON_W-1:0] v_out,
  output logic                       spike,
  output logic signed [NEURON_W-1:0] sh_a,
  output logic        [3:0]          sh_b,
  output logic                       sh_flag,
`ifdef LIF_SPIKE_COUNT_EN
  output logic        [15:0]         spike_count,
  input  logic                       cnt_clr,
`endif
  input  logic signed [NEURON_W-1:0] sh_result
);

  if (!shift_legal(LEAK_SHIFT)) begin : g_bad_leak_shift
    $error("lif_neuron_integrator: LEAK_SHIFT not supported by the shift unit");
  end
  if (!shift_legal(GAIN_SHIFT)) begin : g_bad_gain_shift
    $error("lif_neuron_integrator: GAIN_SHIFT not supported by the shift unit");
  end
  if ((REFRAC_CYCLES < 0) || (REFRAC_CYCLES > 15)) begin : g_bad_refrac
    $error("lif_neuron_integrator: REFRAC_CYCLES must be 0..15");
  end

  localparam logic signed [NEURON_W-1:0] V_TH_S      = NEURON_W'(V_TH);
  localparam logic signed [NEURON_W-1:0] V_RESET_S   = NEURON_W'(V_RESET);
  localparam logic        [3:0]          LEAK_B      = 4'(LEAK_SHIFT);
  localparam logic        [3:0]          GAIN_B      = 4'(GAIN_SHIFT);
  localparam logic        [3:0]          REFRAC_INIT = 4'(REFRAC_CYCLES);

  state_e                       state_q, state_d;
  logic signed [NEURON_W-1:0]   v_q, v_d;
  logic signed [NEURON_W-1:0]   acc_q, acc_d;
  logic signed [NEURON_W-1:0]   i_reg_q, i_reg_d;
  logic signed [NEURON_W-1:0]   lk_a_q, lk_a_d;
  logic        [3:0]            refrac_q, refrac_d;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;
  logic                         spike_q, spike_d;
  logic signed [NEURON_W-1:0]   v_out_q, v_out_d;

  logic signed [NEURON_W-1:0]   addsub_a;
  logic                         addsub_sub;
  logic signed [NEURON_W-1:0]   addsub_y;
  logic                         fire;

  // One shared clamp adder: subtracts the leak in LEAK, adds the gain term in GAIN.
  assign addsub_a   = (state_q == ST_GAIN) ? acc_q : v_q;
  assign addsub_sub = (state_q == ST_LEAK);

  lif_sat_addsub u_addsub (
    .a   (addsub_a),
    .b   (sh_result),
    .sub (addsub_sub),
    .y   (addsub_y)
  );

  assign fire = (state_q == ST_UPDATE) && (refrac_q == 4'd0) && (acc_q >= V_TH_S);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      v_q         <= V_RESET_S;
      acc_q       <= '0;
      i_reg_q     <= '0;
      lk_a_q      <= '0;
      refrac_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      spike_q     <= 1'b0;
      v_out_q     <= V_RESET_S;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      acc_q       <= acc_d;
      i_reg_q     <= i_reg_d;
      lk_a_q      <= lk_a_d;
      refrac_q    <= refrac_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      spike_q     <= spike_d;
      v_out_q     <= v_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid && in_ready_q) state_d = ST_LEAK;
      ST_LEAK:   state_d = ST_GAIN;
      ST_GAIN:   state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_HOLD;
      ST_HOLD:   if (out_valid_q && out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    v_d         = v_q;
    acc_d       = acc_q;
    i_reg_d     = i_reg_q;
    lk_a_d      = lk_a_q;
    refrac_d    = refrac_q;
    out_valid_d = out_valid_q;
    spike_d     = spike_q;
    v_out_d     = v_out_q;
    in_ready_d  = (state_d == ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) i_reg_d = i_in;
      end
      ST_LEAK: begin
        acc_d  = addsub_y;
        lk_a_d = v_q;
      end
      ST_GAIN: begin
        acc_d = addsub_y;
      end
      ST_UPDATE: begin
        if (refrac_q != 4'd0) begin
          v_d      = V_RESET_S;
          spike_d  = 1'b0;
          refrac_d = refrac_q - 4'd1;
        end else if (fire) begin
          v_d      = V_RESET_S;
          spike_d  = 1'b1;
          refrac_d = REFRAC_INIT;
        end else begin
          v_d      = acc_q;
          spike_d  = 1'b0;
        end
        v_out_d     = v_d;
        out_valid_d = 1'b1;
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          spike_d     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outside LEAK/GAIN the shift unit keeps seeing the last leak operand and amount.
  always_comb begin
    sh_a = lk_a_q;
    sh_b = LEAK_B;
    case (state_q)
      ST_LEAK: sh_a = v_q;
      ST_GAIN: begin
        sh_a = i_reg_q;
        sh_b = GAIN_B;
      end
      default: ;
    endcase
  end

  assign sh_flag   = 1'b1;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign spike     = spike_q;
  assign v_out     = v_out_q;

`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0] spike_count_q, spike_count_d;

  always_comb begin
    spike_count_d = spike_count_q;
    if (cnt_clr) begin
      spike_count_d = '0;
    end else if (fire && (spike_count_q != 16'hFFFF)) begin
      spike_count_d = spike_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_count_q <= '0;
    end else begin
      spike_count_q <= spike_count_d;
    end
  end

  assign spike_count = spike_count_q;
`endif

endmodule

// File: tb/tb_lif_neuron_integrator.sv
// tb/tb_lif_neuron_integrator.sv - self-checking bench for lif_neuron_integrator
module tb_lif_neuron_integrator;

  localparam int LEAK_SHIFT    = 4;
  localparam int GAIN_SHIFT    = 3;
  localparam int V_TH          = 1000;
  localparam int V_RESET       = 0;
  localparam int REFRAC_CYCLES = 2;
  localparam int SAT_MAX       = 1048575;
  localparam int SAT_MIN       = -1048576;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic signed [20:0] i_in;
  logic out_valid;
  logic out_ready;
  logic signed [20:0] v_out;
  logic spike;
  logic signed [20:0] sh_a;
  logic [3:0] sh_b;
  logic sh_flag;
  logic signed [20:0] sh_result;
`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0] spike_count;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Shift unit stand-in: combinational arithmetic shift.
  assign sh_result = sh_flag ? (sh_a >>> sh_b) : (sh_a <<< sh_b);

  lif_neuron_integrator #(
    .LEAK_SHIFT    (LEAK_SHIFT),
    .GAIN_SHIFT    (GAIN_SHIFT),
    .V_TH          (V_TH),
    .V_RESET       (V_RESET),
    .REFRAC_CYCLES (REFRAC_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i_in      (i_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .v_out     (v_out),
    .spike     (spike),
    .sh_a      (sh_a),
    .sh_b      (sh_b),
    .sh_flag   (sh_flag),
`ifdef LIF_SPIKE_COUNT_EN
    .spike_count (spike_count),
    .cnt_clr     (1'b0),
`endif
    .sh_result (sh_result)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int legal_shift(input int s);
    return ((s == 3) || (s == 4) || ((s >= 6) && (s <= 9))) ? 1 : 0;
  endfunction

  function automatic int clamp(input int x);
    if (x > SAT_MAX) return SAT_MAX;
    if (x < SAT_MIN) return SAT_MIN;
    return x;
  endfunction

  // Reference neuron: membrane state plus refractory count, updated once per result.
  int m_v, m_refrac, p_i, acc_cyc, exp_v, exp_s;
  bit p_valid, held;

  task automatic model_step(input int i);
    int acc;
    acc = clamp(m_v - (m_v >>> LEAK_SHIFT));
    acc = clamp(acc + (i >>> GAIN_SHIFT));
    if (m_refrac > 0) begin
      m_v = V_RESET; exp_s = 0; m_refrac--;
    end else if (acc >= V_TH) begin
      m_v = V_RESET; exp_s = 1; m_refrac = REFRAC_CYCLES;
    end else begin
      m_v = acc; exp_s = 0;
    end
    exp_v = m_v;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_v = V_RESET; m_refrac = 0; p_valid = 0; held = 0;
    end else begin
      chk("sh_flag", int'(sh_flag), 1);
      chk("sh_b_legal", legal_shift(int'(sh_b)), 1);
      if (out_valid) begin
        if (!held) begin
          chk("pending_sample", int'(p_valid), 1);
          chk("latency_edges", cyc - acc_cyc, 3);
          model_step(p_i);
          p_valid = 0;
        end
        chk("model_v_out", int'(v_out), exp_v);
        chk("model_spike", int'(spike), exp_s);
        chk("in_ready_while_out", int'(in_ready), 0);
        held = !out_ready;
      end else begin
        chk("spike_without_valid", int'(spike), 0);
        held = 0;
      end
      if (in_valid && in_ready) begin
        p_i = int'(i_in); p_valid = 1; acc_cyc = cyc + 1;
      end
    end
  end

  int lk_a, lk_b, g_a, g_b;

  task automatic wait_out(output int v, output int s);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("out_valid_timeout", int'(out_valid), 1);
    v = int'(v_out);
    s = int'(spike);
  endtask

  // Called and returns at #1 after a rising edge; out_ready assumed high.
  task automatic send(input int i, output int v, output int s);
    int n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("in_ready_timeout", int'(in_ready), 1);
    i_in = 21'(i); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    lk_a = int'(sh_a); lk_b = int'(sh_b);
    @(posedge clk); #1;
    g_a = int'(sh_a); g_b = int'(sh_b);
    wait_out(v, s);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int v, s;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; i_in = '0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_spike", int'(spike), 0);
    chk("rst_v_out", int'(v_out), 0);
    chk("rst_sh_a", int'(sh_a), 0);
    chk("rst_sh_b", int'(sh_b), 4);
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", int'(in_ready), 0);
    @(posedge clk); #1 chk("in_ready_after_edge", int'(in_ready), 1);

    send(800, v, s);
    chk("t2_v", v, 100); chk("t2_spike", s, 0);
    chk("t2_leak_sh_a", lk_a, 0); chk("t2_leak_sh_b", lk_b, 4);
    chk("t2_gain_sh_a", g_a, 800); chk("t2_gain_sh_b", g_b, 3);

    do_reset();
    send(8000, v, s); chk("t3_fire_v", v, 0); chk("t3_fire_spike", s, 1);
    send(800, v, s);  chk("t3_refrac1_v", v, 0); chk("t3_refrac1_spike", s, 0);
    send(800, v, s);  chk("t3_refrac2_v", v, 0); chk("t3_refrac2_spike", s, 0);
    send(800, v, s);  chk("t3_after_v", v, 100); chk("t3_after_spike", s, 0);

    do_reset();
    send(-1280, v, s); chk("t4_neg_v", v, -160);
    send(0, v, s);     chk("t4_leak_v", v, -150);

    out_ready = 1'b0; i_in = 21'(800); in_valid = 1'b1;
    @(posedge clk); #1;
    wait_out(v, s);
    chk("t5_v", v, -40); chk("t5_spike", s, 0);
    repeat (5) begin
      @(negedge clk);
      chk("t5_hold_valid", int'(out_valid), 1);
      chk("t5_hold_v", int'(v_out), -40);
      chk("t5_hold_spike", int'(spike), 0);
      chk("t5_hold_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_released_valid", int'(out_valid), 0);
    chk("t5_released_in_ready", int'(in_ready), 1);
    @(posedge clk); #1 in_valid = 1'b0;
    chk("t5_next_accepted", int'(in_ready), 0);
    wait_out(v, s); chk("t5_next_v", v, 63);
    @(posedge clk); #1;

    i_in = 21'(800); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("t6_async_out_valid", int'(out_valid), 0);
    chk("t6_async_v_out", int'(v_out), 0);
    chk("t6_async_in_ready", int'(in_ready), 0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk); chk("t6_no_out_valid", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    send(800, v, s); chk("t6_after_v", v, 100);

    do_reset();
    send(SAT_MIN, v, s); chk("t7_first_v", v, -131072);
    for (int k = 0; k < 15; k++) send(SAT_MIN, v, s);
    chk("t7_sat_v", v, SAT_MIN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
